// File: rtl/user_pkg.sv
// rtl/user_pkg.sv - user-domain shared types: manager indices and copy engine states
//
// Purpose: constants and enums shared by the user-domain top and its managers.
// Ports:   none (package).
package user_pkg;

    localparam int unsigned NumUserDomainManagers = 1;

    // Crossbar manager port index for each user-domain manager.
    typedef enum int unsigned {
        UserCopyMgr = 0
    } user_mgr_e;

    typedef enum logic [2:0] {
        COPY_IDLE   = 3'd0,
        COPY_RD_REQ = 3'd1,
        COPY_RD_RSP = 3'd2,
        COPY_WR_REQ = 3'd3,
        COPY_WR_RSP = 3'd4,
        COPY_DONE   = 3'd5
    } copy_state_e;

endpackage

// File: rtl/user_obi_copy_mgr.sv
// rtl/user_obi_copy_mgr.sv - single-outstanding OBI manager copying N words src -> dst
//
// Purpose: reads one 32-bit word, writes it, advances both addresses, repeats
//          num_words times. Only one OBI transaction is ever in flight.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   start_i                           start pulse (honoured only when idle)
//   src_addr_i, dst_addr_i            byte addresses, low two bits ignored
//   num_words_i                       words to copy (0 = no bus traffic)
//   busy_o, done_o, error_o           status: not idle, completion pulse, sticky err
//   obi_req_o .. obi_aid_o            OBI request channel
//   obi_rvalid_i .. obi_rid_i         OBI response channel (rid ignored)
module user_obi_copy_mgr
    import user_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned LenWidth  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   src_addr_i,
    input  logic [AddrWidth-1:0]   dst_addr_i,
    input  logic [LenWidth-1:0]    num_words_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    output logic [IdWidth-1:0]     obi_aid_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i,
    input  logic [IdWidth-1:0]     obi_rid_i
);

    copy_state_e            state_q, state_d;
    logic [AddrWidth-1:0]   src_q, src_d;
    logic [AddrWidth-1:0]   dst_q, dst_d;
    logic [LenWidth-1:0]    cnt_q, cnt_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic                   error_q, error_d;

    // Response id is meaningless with a single outstanding transaction.
    logic unused_inputs;
    assign unused_inputs = ^{obi_rid_i, src_addr_i[1:0], dst_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= COPY_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        error_d     = error_q;
        obi_req_o   = 1'b0;
        obi_we_o    = 1'b0;
        obi_addr_o  = '0;
        obi_be_o    = '0;
        obi_wdata_o = '0;

        unique case (state_q)
            COPY_IDLE: begin
                if (start_i) begin
                    src_d   = {src_addr_i[AddrWidth-1:2], 2'b00};
                    dst_d   = {dst_addr_i[AddrWidth-1:2], 2'b00};
                    cnt_d   = num_words_i;
                    error_d = 1'b0;
                    state_d = (num_words_i == '0) ? COPY_DONE : COPY_RD_REQ;
                end
            end
            COPY_RD_REQ: begin
                obi_req_o  = 1'b1;
                obi_addr_o = src_q;
                obi_be_o   = '1;
                if (obi_gnt_i) begin
                    state_d = COPY_RD_RSP;
                end
            end
            COPY_RD_RSP: begin
                if (obi_rvalid_i) begin
                    if (obi_err_i) begin
                        error_d = 1'b1;
                        state_d = COPY_DONE;
                    end else begin
                        data_d  = obi_rdata_i;
                        state_d = COPY_WR_REQ;
                    end
                end
            end
            COPY_WR_REQ: begin
                obi_req_o   = 1'b1;
                obi_we_o    = 1'b1;
                obi_addr_o  = dst_q;
                obi_be_o    = '1;
                obi_wdata_o = data_q;
                if (obi_gnt_i) begin
                    state_d = COPY_WR_RSP;
                end
            end
            COPY_WR_RSP: begin
                if (obi_rvalid_i) begin
                    if (obi_err_i) begin
                        error_d = 1'b1;
                        state_d = COPY_DONE;
                    end else begin
                        // Addresses wrap naturally at 2^AddrWidth.
                        src_d   = src_q + AddrWidth'(4);
                        dst_d   = dst_q + AddrWidth'(4);
                        cnt_d   = cnt_q - LenWidth'(1);
                        state_d = (cnt_q == LenWidth'(1)) ? COPY_DONE : COPY_RD_REQ;
                    end
                end
            end
            COPY_DONE: begin
                state_d = COPY_IDLE;
            end
            default: begin
                state_d = COPY_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != COPY_IDLE);
    assign done_o    = (state_q == COPY_DONE);
    assign error_o   = error_q;
    assign obi_aid_o = '0;

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// tb/tb_user_obi_copy_mgr.sv - self-checking bench for user_obi_copy_mgr
module tb_user_obi_copy_mgr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] num_words = '0;
    logic        busy, done, error;
    logic        req, gnt, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [0:0]  aid;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        err = 1'b0;
    logic [0:0]  rid = 1'b0;

    int checks = 0;
    int errors = 0;

    user_obi_copy_mgr dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .num_words_i  (num_words),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .obi_req_o    (req),
        .obi_gnt_i    (gnt),
        .obi_addr_o   (addr),
        .obi_we_o     (we),
        .obi_be_o     (be),
        .obi_wdata_o  (wdata),
        .obi_aid_o    (aid),
        .obi_rvalid_i (rvalid),
        .obi_rdata_i  (rdata),
        .obi_err_i    (err),
        .obi_rid_i    (rid)
    );

    always #5 clk = ~clk;

    // ---------------- memory slave ----------------
    logic [31:0] seed = 32'h1234_5678;
    logic [31:0] mem [logic [31:0]];
    int          err_idx = -1;   // transaction index answered with err
    int          force_idx = -1; // transaction index with a forced grant stall
    int          force_val = 0;
    int          rand_max = 0;
    logic        clr = 1'b0;
    int          txn = 0;
    int          stall_ctr = 0;
    int          stall_total = 0;
    logic [31:0] log_addr [$];
    logic        log_we [$];
    logic [31:0] log_wdata [$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic int stall_for(input int t);
        if (t == force_idx) return force_val;
        return (rand_max > 0) ? int'($urandom_range(0, rand_max)) : 0;
    endfunction

    assign gnt = req && (stall_ctr == 0);

    always @(posedge clk) begin
        rvalid <= 1'b0;
        err    <= 1'b0;
        rdata  <= '0;
        if (rst || clr) begin
            txn = 0;
            stall_total = 0;
            stall_ctr <= stall_for(0);
            mem.delete();
            log_addr.delete();
            log_we.delete();
            log_wdata.delete();
        end else if (req && !gnt) begin
            stall_ctr <= stall_ctr - 1;
            stall_total++;
        end else if (req && gnt) begin
            log_addr.push_back(addr);
            log_we.push_back(we);
            log_wdata.push_back(wdata);
            rvalid <= 1'b1;
            if (txn == err_idx) begin
                err <= 1'b1;
            end else if (we) begin
                mem[addr] = wdata;
            end else begin
                rdata <= mem.exists(addr) ? mem[addr] : init_word(addr);
            end
            txn++;
            stall_ctr <= stall_for(txn);
        end
    end

    // ---------------- request stability monitor ----------------
    logic        rst_seen = 1'b1;
    logic        hold_pend = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic [3:0]  h_be;

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        if (hold_pend && !rst_seen) begin
            checks++;
            if (req !== 1'b1 || addr !== h_addr || we !== h_we || be !== h_be ||
                (h_we && wdata !== h_wdata)) begin
                errors++;
                $display("FAIL hold_stable: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                         req, addr, we, wdata, h_addr, h_we, h_wdata);
            end
        end
        hold_pend = req && !gnt && !rst;
        h_addr = addr;
        h_we = we;
        h_be = be;
        h_wdata = wdata;
    end

    // ---------------- scenario runner with reference model ----------------
    task automatic do_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                           input int n, input int e_idx, input int f_idx, input int f_val,
                           input int r_max, input bit poke);
        logic [31:0] model_mem [logic [31:0]];
        logic [31:0] exp_addr [$];
        logic        exp_we [$];
        logic [31:0] exp_wdata [$];
        logic [31:0] ra, wa, d;
        int          t, cyc, done_cyc, busy_cnt, req_cnt, exp_done;
        bit          exp_err;

        // Reference: sequential word copy with error abort, over byte addresses.
        t = 0;
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            ra = (src & 32'hFFFF_FFFC) + 32'(4 * i);
            wa = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
            d  = model_mem.exists(ra) ? model_mem[ra] : init_word(ra);
            exp_addr.push_back(ra); exp_we.push_back(1'b0); exp_wdata.push_back('0);
            if (t++ == e_idx) begin exp_err = 1'b1; break; end
            exp_addr.push_back(wa); exp_we.push_back(1'b1); exp_wdata.push_back(d);
            if (t++ == e_idx) begin exp_err = 1'b1; break; end
            model_mem[wa] = d;
        end

        @(negedge clk);
        err_idx = e_idx; force_idx = f_idx; force_val = f_val; rand_max = r_max;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        src_addr = src; dst_addr = dst; num_words = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done_cyc = -1; busy_cnt = 0; req_cnt = 0;
        while (cyc < 600) begin
            if (cyc == 1) begin
                checks++;
                if (error !== 1'b0) begin
                    errors++;
                    $display("FAIL %s error_cleared: got %b, required 0", name, error);
                end
            end
            if (busy) busy_cnt++;
            if (req) req_cnt++;
            if (done) begin done_cyc = cyc; break; end
            if (poke) begin
                start = (cyc == 2);
                src_addr = 32'h4000_0000; dst_addr = 32'h5000_0000; num_words = 16'd7;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        exp_done = 1 + 2 * exp_addr.size() + stall_total;
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (busy_cnt != exp_done) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, exp_done);
        end
        checks++;
        if (error !== exp_err) begin
            errors++;
            $display("FAIL %s error_o: got %b, required %b", name, error, exp_err);
        end
        if (n == 0) begin
            checks++;
            if (req_cnt != 0) begin
                errors++;
                $display("FAIL %s no_traffic: req cycles %0d, required 0", name, req_cnt);
            end
        end
        checks++;
        if (log_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL %s txn_count: got %0d, required %0d", name, log_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (log_addr[i] !== exp_addr[i] || log_we[i] !== exp_we[i] ||
                    (exp_we[i] && log_wdata[i] !== exp_wdata[i])) begin
                    errors++;
                    $display("FAIL %s txn%0d: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                             name, i, log_addr[i], log_we[i], log_wdata[i],
                             exp_addr[i], exp_we[i], exp_wdata[i]);
                end
            end
        end
        // Engine must return to idle and stay there (a stray start must not queue).
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || req !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_after: busy=%b done=%b req=%b, required 0 0 0", name, busy, done, req);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, error, req, we, be, aid} !== 10'b0 || addr !== 32'h0 || wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b error=%b req=%b we=%b be=%h addr=%h wdata=%h, required all 0",
                     busy, done, error, req, we, be, addr, wdata);
        end
    endtask

    task automatic test_basic();
        do_copy("basic", 32'h2000_0000, 32'h2000_0100, 3, -1, -1, 0, 0, 1'b0);
    endtask

    task automatic test_zero_len();
        do_copy("zero_len", 32'h2000_0000, 32'h2000_0100, 0, -1, -1, 0, 0, 1'b0);
    endtask

    task automatic test_grant_stall();
        do_copy("grant_stall", 32'h2000_0000, 32'h2000_0100, 3, -1, 3, 5, 0, 1'b0);
    endtask

    task automatic test_error();
        do_copy("read_err", 32'h2000_0000, 32'h2000_0200, 4, 2, -1, 0, 0, 1'b0);
        do_copy("after_err", 32'h2000_0000, 32'h2000_0200, 2, -1, -1, 0, 0, 1'b0);
        do_copy("write_err", 32'h2100_0000, 32'h2100_0400, 3, 3, -1, 0, 1, 1'b0);
    endtask

    task automatic test_alignment_wrap();
        do_copy("unaligned", 32'h2000_0003, 32'h2000_0102, 1, -1, -1, 0, 0, 1'b0);
        do_copy("addr_wrap", 32'hFFFF_FFFC, 32'h3000_0000, 2, -1, -1, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        err_idx = -1; force_idx = 1; force_val = 30; rand_max = 0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        src_addr = 32'h2000_0000; dst_addr = 32'h2000_0100; num_words = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(req && we) && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (!(req && we)) begin
            errors++;
            $display("FAIL reset_mid_reach_wr: req=%b we=%b, required 1 1", req, we);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: req=%b busy=%b, required 0 0", req, busy);
        end
        rst = 1'b0;
        do_copy("after_reset", 32'h2000_0040, 32'h2000_0180, 3, -1, -1, 0, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        do_copy("start_busy", 32'h2000_0800, 32'h2000_0900, 2, -1, -1, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        int n, e;
        for (int r = 0; r < 10; r++) begin
            seed = $urandom;
            n = int'($urandom_range(1, 6));
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
            do_copy("random", $urandom, $urandom, n, e, -1, 0, 3, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_grant_stall();
        test_error();
        test_alignment_wrap();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
